// File: rtl/load_unit_pkg.sv
// Shared load-op encoding and the byte/halfword/word extraction helper for the load unit.
package load_unit_pkg;

  localparam int LOAD_OP_WIDTH = 3;

  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'd0;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'd1;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'd2;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'd3;
  localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'd4;

  // Picks the addressed lane out of the bus word and extends it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [LOAD_OP_WIDTH-1:0] op,
                                               input logic [1:0] align,
                                               input logic [31:0] rdata);
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] res;
    byte_val = rdata[8*align +: 8];
    half_val = rdata[16*align[1] +: 16];
    case (op)
      LOAD_OP_LB:  res = {{24{byte_val[7]}}, byte_val};
      LOAD_OP_LH:  res = {{16{half_val[15]}}, half_val};
      LOAD_OP_LBU: res = {24'd0, byte_val};
      LOAD_OP_LHU: res = {16'd0, half_val};
      default:     res = rdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_decoder.sv
// Combinational decode of a load request into an op code plus illegal/misaligned fault flags.
module load_decoder
  import load_unit_pkg::*;
(
  input  logic [2:0]               funct3,
  input  logic                     amo_operation_load,
  input  logic [1:0]               addr_align_bits,
  output logic [LOAD_OP_WIDTH-1:0] load_op,
  output logic                     is_load_unaligned,
  output logic                     is_load_illegal
);

  always_comb begin
    load_op         = LOAD_OP_LW;
    is_load_illegal = 1'b0;
    if (!amo_operation_load) begin
      case (funct3)
        3'b000:  load_op = LOAD_OP_LB;
        3'b001:  load_op = LOAD_OP_LH;
        3'b010:  load_op = LOAD_OP_LW;
        3'b100:  load_op = LOAD_OP_LBU;
        3'b101:  load_op = LOAD_OP_LHU;
        default: is_load_illegal = 1'b1;
      endcase
    end
  end

  // Illegal wins: an illegal request never reports misalignment.
  always_comb begin
    is_load_unaligned = 1'b0;
    if (!is_load_illegal) begin
      case (load_op)
        LOAD_OP_LH, LOAD_OP_LHU: is_load_unaligned = addr_align_bits[0];
        LOAD_OP_LW:              is_load_unaligned = |addr_align_bits;
        default:                 is_load_unaligned = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/load_unit.sv
// Multicycle load unit: decodes and checks a load, runs one valid/ready bus read, returns the extended value.
// Bus handshake: mem_valid rises the cycle after an accepted start and holds with a stable mem_addr
// until the cycle mem_ready is seen high; mem_rdata is taken in that same cycle and mem_valid then drops.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic            amo_operation_load,
  input  logic [XLEN-1:0] addr,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            is_load_unaligned,
  output logic            is_load_illegal,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t                   state;
  logic [LOAD_OP_WIDTH-1:0] op_q;
  logic [1:0]               align_q;

  logic [LOAD_OP_WIDTH-1:0] dec_op;
  logic                     dec_unaligned;
  logic                     dec_illegal;

  load_decoder u_load_decoder (
    .funct3             (funct3),
    .amo_operation_load (amo_operation_load),
    .addr_align_bits    (addr[1:0]),
    .load_op            (dec_op),
    .is_load_unaligned  (dec_unaligned),
    .is_load_illegal    (dec_illegal)
  );

  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state             <= ST_IDLE;
      op_q              <= LOAD_OP_LW;
      align_q           <= 2'b00;
      mem_valid         <= 1'b0;
      mem_addr          <= '0;
      result            <= '0;
      done              <= 1'b0;
      is_load_unaligned <= 1'b0;
      is_load_illegal   <= 1'b0;
    end else begin
      done              <= 1'b0;
      is_load_unaligned <= 1'b0;
      is_load_illegal   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= dec_op;
            align_q  <= addr[1:0];
            mem_addr <= {addr[XLEN-1:2], 2'b00};
            if (dec_illegal || dec_unaligned) begin
              state             <= ST_FAULT;
              done              <= 1'b1;
              is_load_illegal   <= dec_illegal;
              is_load_unaligned <= dec_unaligned;
            end else begin
              state     <= ST_REQ;
              mem_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            result    <= load_extract(op_q, align_q, mem_rdata);
            mem_valid <= 1'b0;
            done      <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_unit.md
# load_unit

Multicycle load unit for the kianv RV32IMA core. It is the read-side counterpart of the store path. It accepts a load request (funct3, byte address, AMO flag) from the control FSM and decodes the access width. It checks alignment, runs a valid/ready read transaction on the data bus, then extracts the addressed byte, halfword or word and sign- or zero-extends it into a registered 32-bit writeback value. Misaligned and illegal-width loads raise a fault without touching the bus, so the trap logic can take the exception.

## Interface
Parameters:
- `XLEN`, default 32: data and address width. Only 32 is supported.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `resetn`: input, 1 bit. Asynchronous, active-low reset.
- `start`: input, 1 bit. Single-cycle load request pulse. Sampled only in IDLE.
- `funct3`: input, 3 bits. Load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `amo_operation_load`: input, 1 bit. AMO/LR read. Forces a word access.
- `addr`: input, 32 bits. Byte address of the load.
- `mem_valid`: output, 1 bit. Read request to the bus.
- `mem_addr`: output, 32 bits. Word-aligned address, `{addr[31:2],2'b00}`.
- `mem_ready`: input, 1 bit. Bus completion strobe; `mem_rdata` is valid in the same cycle.
- `mem_rdata`: input, 32 bits. Read data (full word).
- `result`: output, 32 bits. Extended load value. Holds until the next completion.
- `done`: output, 1 bit. One-cycle completion pulse.
- `is_load_unaligned`: output, 1 bit. Misaligned fault, valid with `done`.
- `is_load_illegal`: output, 1 bit. Unsupported funct3 (011, 110, 111), valid with `done`.

## Operation
- Decode:
  - AMO forces LOAD_OP_LW.
  - Otherwise funct3 maps to LB, LH, LW, LBU or LHU.
  - 011, 110 and 111 are illegal.
- Misalignment:
  - Halfword loads: `addr[0]`.
  - Word and AMO loads: `|addr[1:0]`.
  - Byte loads: never.
- On `start`, register funct3/AMO, `addr[1:0]` and `mem_addr`.
- FSM states, each one cycle unless noted:
  - IDLE: on `start` with an illegal or misaligned request, go to FAULT. On any other `start`, go to REQ.
  - REQ: `mem_valid`=1. Hold until `mem_ready`=1, then capture the extended data into `result` and go to DONE.
  - DONE: `done`=1, both fault flags 0. Go to IDLE.
  - FAULT: `done`=1 and exactly one flag set; illegal takes priority over unaligned. `result` is unchanged. `mem_valid` stays 0 throughout. Go to IDLE.
- Extraction uses `byte = rdata[8*a +: 8]` with `a=addr[1:0]` and `half = rdata[16*a[1] +: 16]`:
  - LB, LH: sign-extend.
  - LBU, LHU: zero-extend.
  - LW and AMO: full word.
- `mem_addr` and the registered request stay stable while `mem_valid`=1.
- `start` outside IDLE is ignored; no queueing.

## Timing
- Reset: every output is 0 (`mem_valid`, `mem_addr`, `result`, `done`, both flags) and the state is IDLE. Reset takes effect asynchronously, so a transaction in flight is abandoned and `mem_valid` falls immediately.
- Normal load, with `start` in cycle 0:
  - `mem_valid`=1 from cycle 1.
  - If `mem_ready` arrives in cycle k≥1, `done` and the new `result` appear in cycle k+1.
  - Minimum latency is 2 cycles.
- Fault, with `start` in cycle 0: `done` and the flag appear in cycle 1, with no bus activity.
- `mem_ready` while `mem_valid`=0 is ignored.
- Back-to-back: a new `start` is accepted in the cycle after `done` (IDLE). Throughput is one load per ≥3 cycles.
- `done`, the flags and `mem_valid` are registered outputs, with no combinational path from inputs.

## Structure
- Add `LOAD_OP_WIDTH` and `LOAD_OP_LB/LH/LW/LBU/LHU` to `riscv_defines.svh`, next to the STORE_OP constants.
- The FSM state enum is local to the module.
- One combinational sub-module, `load_decoder`:
  - Inputs: funct3, `amo_operation_load`, `addr_align_bits`.
  - Outputs: LOADop, `is_load_unaligned`, `is_load_illegal`.
  - `load_unit` instantiates it on the `start`-cycle inputs.

## Test plan
- LB, `addr`=0x1003, `mem_rdata`=0x80FF1234, `mem_ready` on the first REQ cycle:
  - `mem_addr`=0x1000.
  - `result`=0xFFFFFF80 and `done` in cycle 2.
- LHU, `addr`=0x2002, `mem_rdata`=0x9ABC5678, `mem_ready` after 3 wait cycles:
  - `result`=0x00009ABC.
  - `done` in cycle 5.
  - `mem_valid` held high in cycles 1–4.
- LW, `addr`=0x3006: `is_load_unaligned`=1 and `done` in cycle 1; `mem_valid` never asserted; `result` unchanged.
- AMO with funct3=000 and `addr`=0x4001: unaligned fault. AMO with `addr`=0x4000 and `rdata`=0xDEADBEEF: `result`=0xDEADBEEF.
- funct3=111: `is_load_illegal`=1 and `is_load_unaligned`=0, even with `addr`=0x5003.
- Reset mid-op: `resetn` low while in REQ forces `mem_valid`=0 and `done`=0 immediately. After release, a `start` raised during REQ is not accepted, and a new LW completes normally.
